// File: rtl/pi_ratio_div.sv
// Divides the in-circle hit count by the sample count to produce pi ~= 4*count/total
// as unsigned Q3.FRAC, using a restoring divider that retires one quotient bit per clock.
module pi_ratio_div #(
   parameter int CW   = 20,
   parameter int FRAC = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [CW-1:0]   count_in,
   input  logic [CW-1:0]   total,
   output logic            busy,
   output logic            done,
   output logic [FRAC+2:0] pi_q,
   output logic            err
);

   localparam int QW    = FRAC + 3;
   localparam int DW    = CW + FRAC + 2;
   localparam int ITER  = DW;
   localparam int CNT_W = $clog2(ITER);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

   typedef enum logic [1:0] {S_IDLE, S_DIV, S_FIN} state_e;

   state_e          state_q, state_d;
   logic [DW-1:0]   dvd_q, dvd_d;
   logic [CW-1:0]   dvs_q, dvs_d;
   logic [CW-1:0]   rem_q, rem_d;
   logic [QW-1:0]   quo_q, quo_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic            bad_q, bad_d;
   logic [QW-1:0]   pi_res_q, pi_res_d;
   logic            err_q, err_d;
   logic            done_q, done_d;

   // After each step the remainder is below the divisor, so CW bits hold it;
   // only the freshly shifted value needs the extra top bit.
   logic [CW:0]     rem_sh;
   logic            q_bit;
   logic [CW-1:0]   rem_sub;

   assign rem_sh  = {rem_q, dvd_q[DW-1]};
   assign q_bit   = (rem_sh >= {1'b0, dvs_q});
   assign rem_sub = rem_sh[CW-1:0] - dvs_q;

   always_comb begin
      state_d  = state_q;
      dvd_d    = dvd_q;
      dvs_d    = dvs_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      cnt_d    = cnt_q;
      bad_d    = bad_q;
      pi_res_d = pi_res_q;
      err_d    = err_q;
      done_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if ((total == '0) || (count_in > total)) begin
                  bad_d   = 1'b1;
                  state_d = S_FIN;
               end else begin
                  dvd_d   = {count_in, {(FRAC+2){1'b0}}};
                  dvs_d   = total;
                  rem_d   = '0;
                  quo_d   = '0;
                  cnt_d   = '0;
                  bad_d   = 1'b0;
                  state_d = S_DIV;
               end
            end
         end
         S_DIV: begin
            // Quotient never exceeds 4.0, so only its low QW bits are kept.
            rem_d = q_bit ? rem_sub : rem_sh[CW-1:0];
            dvd_d = dvd_q << 1;
            quo_d = {quo_q[QW-2:0], q_bit};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d = S_FIN;
            end
         end
         S_FIN: begin
            done_d   = 1'b1;
            pi_res_d = bad_q ? '1 : quo_q;
            err_d    = bad_q;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         dvd_q    <= '0;
         dvs_q    <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         cnt_q    <= '0;
         bad_q    <= 1'b0;
         pi_res_q <= '0;
         err_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         dvd_q    <= dvd_d;
         dvs_q    <= dvs_d;
         rem_q    <= rem_d;
         quo_q    <= quo_d;
         cnt_q    <= cnt_d;
         bad_q    <= bad_d;
         pi_res_q <= pi_res_d;
         err_q    <= err_d;
         done_q   <= done_d;
      end
   end

   assign busy = (state_q != S_IDLE);
   assign done = done_q;
   assign pi_q = pi_res_q;
   assign err  = err_q;

endmodule

// File: tb/tb_pi_ratio_div.sv
// Randomized and directed checks of pi_ratio_div against an arithmetic model of
// 4*count/total in Q3.16, including latency, busy, ignored starts and mid-op reset.
module tb_pi_ratio_div;

   localparam int CW   = 20;
   localparam int FRAC = 16;
   localparam int QW   = FRAC + 3;
   localparam int LAT_OK  = CW + FRAC + 2 + 1;
   localparam int LAT_ERR = 1;

   logic            clk;
   logic            rst_n;
   logic            start;
   logic [CW-1:0]   count_in;
   logic [CW-1:0]   total;
   logic            busy;
   logic            done;
   logic [QW-1:0]   pi_q;
   logic            err;

   int n_cmp;
   int n_bad;
   logic [QW-1:0] last_pi;
   logic          last_err;

   pi_ratio_div #(.CW(CW), .FRAC(FRAC)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .count_in (count_in),
      .total    (total),
      .busy     (busy),
      .done     (done),
      .pi_q     (pi_q),
      .err      (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // pi = floor(count * 2^(FRAC+2) / total), or all-ones with err on bad operands
   function automatic void model(input longint c, input longint t,
                                 output logic [QW-1:0] p, output logic e);
      longint q;
      if (t == 0 || c > t) begin
         p = {QW{1'b1}};
         e = 1'b1;
      end else begin
         q = (c * (longint'(1) << (FRAC + 2))) / t;
         p = q[QW-1:0];
         e = 1'b0;
      end
   endfunction

   task automatic run_op(input string tag, input logic [CW-1:0] c, input logic [CW-1:0] t,
                         input bit inject);
      logic [QW-1:0] exp_pi;
      logic          exp_err;
      int            lat;
      int            cyc;
      int            busy_bad;
      int            extra;
      bit            got;
      model(longint'(c), longint'(t), exp_pi, exp_err);
      lat = exp_err ? LAT_ERR : LAT_OK;
      @(negedge clk);
      count_in = c;
      total    = t;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start    = 1'b0;
      count_in = CW'($urandom);
      total    = CW'($urandom);
      chk({tag, "/hold_at_start"}, {last_err, last_pi}, {last_err, last_pi});
      chk({tag, "/pi_held"}, pi_q, last_pi);
      cyc = 0;
      got = 1'b0;
      busy_bad = 0;
      while (!got && cyc < LAT_OK + 20) begin
         if (!busy) busy_bad++;
         if (inject && (cyc + 1 == 5 || cyc + 1 == lat)) begin
            start    = 1'b1;
            count_in = CW'($urandom_range(0, 100));
            total    = CW'($urandom_range(101, 1000));
         end
         @(posedge clk);
         cyc++;
         #1;
         start = 1'b0;
         if (done) got = 1'b1;
      end
      chk({tag, "/done_seen"}, got, 1'b1);
      chk({tag, "/latency"}, cyc, lat);
      chk({tag, "/busy_during"}, busy_bad, 0);
      chk({tag, "/busy_at_done"}, busy, 1'b0);
      chk({tag, "/pi"}, pi_q, exp_pi);
      chk({tag, "/err"}, err, exp_err);
      last_pi  = exp_pi;
      last_err = exp_err;
      if (inject) begin
         extra = 0;
         for (int k = 0; k < LAT_OK + 5; k++) begin
            @(posedge clk);
            #1;
            if (done) extra++;
         end
         chk({tag, "/no_extra_done"}, extra, 0);
         chk({tag, "/idle_after"}, busy, 1'b0);
         chk({tag, "/pi_still"}, pi_q, exp_pi);
      end else begin
         @(posedge clk);
         #1;
         chk({tag, "/done_one_cycle"}, done, 1'b0);
      end
   endtask

   initial begin
      int dones;
      logic [CW-1:0] rc;
      logic [CW-1:0] rt;
      n_cmp    = 0;
      n_bad    = 0;
      last_pi  = '0;
      last_err = 1'b0;
      rst_n    = 1'b0;
      start    = 1'b0;
      count_in = '0;
      total    = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset/busy", busy, 1'b0);
      chk("reset/done", done, 1'b0);
      chk("reset/pi", pi_q, 0);
      chk("reset/err", err, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op("quarter", 20'd1, 20'd4, 1'b0);
      run_op("pi_est", 20'd785398, 20'd1000000, 1'b0);
      chk("pi_est/const", last_pi, 19'h3243F);
      run_op("full", 20'd640000, 20'd640000, 1'b0);
      chk("full/const", last_pi, 19'h40000);
      run_op("zero", 20'd0, 20'd640000, 1'b0);
      run_op("tot0", 20'd7, 20'd0, 1'b0);
      chk("tot0/const", last_pi, 19'h7FFFF);
      run_op("c_gt_t", 20'd5, 20'd4, 1'b0);
      run_op("ignore", 20'd3, 20'd4, 1'b1);
      chk("ignore/const", last_pi, 19'h30000);
      run_op("max_ops", 20'hFFFFF, 20'hFFFFF, 1'b0);
      run_op("min_ratio", 20'd1, 20'hFFFFF, 1'b0);

      // Abort a division with reset: nothing may complete afterwards.
      @(negedge clk);
      count_in = 20'd3;
      total    = 20'd7;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("midrst/busy_before", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("midrst/busy", busy, 1'b0);
      chk("midrst/done", done, 1'b0);
      chk("midrst/pi", pi_q, 0);
      chk("midrst/err", err, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      last_pi  = '0;
      last_err = 1'b0;
      dones = 0;
      for (int k = 0; k < LAT_OK + 5; k++) begin
         @(posedge clk);
         #1;
         if (done) dones++;
      end
      chk("midrst/no_done", dones, 0);
      run_op("after_rst", 20'd3, 20'd7, 1'b0);

      for (int i = 0; i < 30; i++) begin
         rt = CW'($urandom_range(1, (1 << CW) - 1));
         case ($urandom_range(0, 9))
            0:       rc = rt + CW'($urandom_range(1, 1000));
            1:       rt = '0;
            default: rc = CW'($urandom_range(0, int'(rt)));
         endcase
         if (rt != '0 && rc > rt && rc < rt) rc = rt;
         run_op($sformatf("rnd%0d", i), rc, rt, ($urandom_range(0, 4) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
